uart_hdx_ctrl: RTL and testbench

- Parametrised half-duplex UART controller for the single-wire ARDUINO_IO serial bus; successor to the fixed 8-bit uart plus external full/half-duplex mux.
- Adds TX/RX FIFOs, a programmable baud divisor, a configurable frame width, an integrated driver-enable with guard time, echo suppression, error flags and an interrupt mask.
- Sits between the soc_system PIO/bridge register interface and the bus tri-state buffer.

---
 rtl/uart_hdx_pkg.sv | 20 ++
 rtl/sync_fifo.sv | 48 ++++
 rtl/uart_hdx_ctrl.sv | 284 ++++++++++++++++++++++++++++
 tb/tb_uart_hdx_ctrl.sv | 243 ++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_hdx_pkg.sv
// rtl/uart_hdx_pkg.sv - register map, status bit positions and FSM state types for uart_hdx_ctrl
package uart_hdx_pkg;

  localparam logic [1:0] A_DATA = 2'd0;
  localparam logic [1:0] A_STAT = 2'd1;
  localparam logic [1:0] A_DIV  = 2'd2;
  localparam logic [1:0] A_IEN  = 2'd3;

  localparam int S_RX_NEMPTY = 0;
  localparam int S_RX_FULL   = 1;
  localparam int S_TX_EMPTY  = 2;
  localparam int S_TX_FULL   = 3;
  localparam int S_RX_OVF    = 4;
  localparam int S_FRM_ERR   = 5;
  localparam int S_TX_DROP   = 6;

  typedef enum logic [1:0] {R_IDLE, R_START, R_DATA, R_STOP} rx_state_t;
  typedef enum logic [2:0] {T_IDLE, T_LEAD, T_START, T_DATA, T_STOP, T_GUARD} tx_state_t;

endpackage

// File: rtl/sync_fifo.sv
// rtl/sync_fifo.sv - show-ahead synchronous FIFO; push on full is accepted only alongside a pop
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic             clk_i,
  input  logic             reset_i,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [CW-1:0]    count;
  logic             do_push;
  logic             do_pop;

  assign empty   = (count == '0);
  assign full    = (count == CW'(DEPTH));
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign dout    = mem[rd_ptr];

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      count <= count + CW'(do_push) - CW'(do_pop);
    end
  end

  always_ff @(posedge clk_i) begin
    if (do_push) mem[wr_ptr] <= din;
  end

endmodule

// File: rtl/uart_hdx_ctrl.sv
// rtl/uart_hdx_ctrl.sv - half-duplex single-wire UART with FIFOs, divisor, driver-enable guard and echo suppression
module uart_hdx_ctrl
  import uart_hdx_pkg::*;
#(
  parameter int DATA_W     = 8,
  parameter int FIFO_DEPTH = 16,
  parameter int DIV_W      = 16,
  parameter int DIV_RST    = 434,
  parameter int GUARD_BITS = 1
) (
  input  logic        clk_i,
  input  logic        reset_i,
  input  logic        ce_i,
  input  logic        wr_i,
  input  logic        rd_i,
  input  logic [1:0]  addr_i,
  input  logic [15:0] data_i,
  output logic [15:0] data_o,
  output logic        irq_o,
  input  logic        rxd_i,
  output logic        txd_o,
  output logic        txen_o
);

  localparam int BIT_W = $clog2(DATA_W);
  localparam int G_W   = (GUARD_BITS < 2) ? 1 : $clog2(GUARD_BITS + 1);

  logic              acc_wr, acc_rd;
  logic [DIV_W-1:0]  div_reg, div_eff, half_bit;
  logic [2:0]        ien;
  logic              tx_drop, frm_err, rx_ovf;
  logic [15:0]       stat_word;

  logic              tx_push, tx_pop, tx_full, tx_empty;
  logic [DATA_W-1:0] tx_dout;
  logic              rx_push, rx_pop, rx_full, rx_empty;
  logic [DATA_W-1:0] rx_dout;

  logic [2:0]        rxd_sync;
  logic              rxd_s, rx_fall, rx_stop_tick;

  rx_state_t         rx_state;
  logic [DIV_W-1:0]  rx_cnt, rx_div;
  logic [BIT_W-1:0]  rx_bit;
  logic [DATA_W-1:0] rx_shift;

  tx_state_t         tx_state;
  logic [DIV_W-1:0]  tx_cnt, tx_div;
  logic [BIT_W-1:0]  tx_bit;
  logic [DATA_W-1:0] tx_shift;
  logic [G_W-1:0]    guard_left;
  logic              tx_go;

  assign acc_wr = ce_i && wr_i;
  assign acc_rd = ce_i && rd_i && !wr_i;

  // Divisors below 3 leave no room for a mid-bit sample, so they are clamped.
  assign div_eff  = (div_reg < DIV_W'(3)) ? DIV_W'(3) : div_reg;
  assign half_bit = (div_eff >> 1) + DIV_W'(div_eff[0]);

  assign tx_push = acc_wr && (addr_i == A_DATA);
  assign rx_pop  = acc_rd && (addr_i == A_DATA) && !rx_empty;

  sync_fifo #(.WIDTH(DATA_W), .DEPTH(FIFO_DEPTH)) u_tx_fifo (
    .clk_i(clk_i), .reset_i(reset_i), .push(tx_push), .pop(tx_pop),
    .din(data_i[DATA_W-1:0]), .dout(tx_dout), .full(tx_full), .empty(tx_empty)
  );

  sync_fifo #(.WIDTH(DATA_W), .DEPTH(FIFO_DEPTH)) u_rx_fifo (
    .clk_i(clk_i), .reset_i(reset_i), .push(rx_push), .pop(rx_pop),
    .din(rx_shift), .dout(rx_dout), .full(rx_full), .empty(rx_empty)
  );

  // Two synchroniser flops plus one history flop for edge detection.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) rxd_sync <= 3'b111;
    else         rxd_sync <= {rxd_sync[1:0], rxd_i};
  end

  assign rxd_s        = rxd_sync[1];
  assign rx_fall      = rxd_sync[2] && !rxd_sync[1];
  assign rx_stop_tick = (rx_state == R_STOP) && (rx_cnt == '0) && !txen_o;
  assign rx_push      = rx_stop_tick && rxd_s;

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      rx_state <= R_IDLE;
      rx_cnt   <= '0;
      rx_div   <= '0;
      rx_bit   <= '0;
      rx_shift <= '0;
    end else if (txen_o) begin
      rx_state <= R_IDLE;
    end else begin
      case (rx_state)
        R_IDLE: begin
          if (rx_fall) begin
            rx_state <= R_START;
            rx_div   <= div_eff;
            rx_cnt   <= half_bit - 1'b1;
          end
        end
        R_START: begin
          if (rx_cnt == '0) begin
            if (rxd_s) begin
              rx_state <= R_IDLE;
            end else begin
              rx_state <= R_DATA;
              rx_cnt   <= rx_div;
              rx_bit   <= '0;
            end
          end else begin
            rx_cnt <= rx_cnt - 1'b1;
          end
        end
        R_DATA: begin
          if (rx_cnt == '0) begin
            rx_shift <= {rxd_s, rx_shift[DATA_W-1:1]};
            rx_cnt   <= rx_div;
            if (rx_bit == BIT_W'(DATA_W - 1)) rx_state <= R_STOP;
            else                              rx_bit   <= rx_bit + 1'b1;
          end else begin
            rx_cnt <= rx_cnt - 1'b1;
          end
        end
        R_STOP: begin
          if (rx_cnt == '0) rx_state <= R_IDLE;
          else              rx_cnt   <= rx_cnt - 1'b1;
        end
        default: rx_state <= R_IDLE;
      endcase
    end
  end

  // RX wins arbitration: a start edge seen this cycle also blocks TX.
  assign tx_go  = (tx_state == T_IDLE) && !tx_empty && (rx_state == R_IDLE) && !rx_fall;
  assign tx_pop = (tx_cnt == '0) &&
                  ((tx_state == T_LEAD) || ((tx_state == T_STOP) && !tx_empty));

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      tx_state   <= T_IDLE;
      txd_o      <= 1'b1;
      txen_o     <= 1'b0;
      tx_cnt     <= '0;
      tx_div     <= '0;
      tx_bit     <= '0;
      tx_shift   <= '0;
      guard_left <= '0;
    end else begin
      case (tx_state)
        T_IDLE: begin
          if (tx_go) begin
            tx_state <= T_LEAD;
            txen_o   <= 1'b1;
            txd_o    <= 1'b1;
            tx_div   <= div_eff;
            tx_cnt   <= div_eff;
          end
        end
        T_LEAD: begin
          if (tx_cnt == '0) begin
            tx_state <= T_START;
            txd_o    <= 1'b0;
            tx_shift <= tx_dout;
            tx_cnt   <= tx_div;
          end else begin
            tx_cnt <= tx_cnt - 1'b1;
          end
        end
        T_START: begin
          if (tx_cnt == '0) begin
            tx_state <= T_DATA;
            txd_o    <= tx_shift[0];
            tx_shift <= tx_shift >> 1;
            tx_bit   <= '0;
            tx_cnt   <= tx_div;
          end else begin
            tx_cnt <= tx_cnt - 1'b1;
          end
        end
        T_DATA: begin
          if (tx_cnt == '0) begin
            tx_cnt <= tx_div;
            if (tx_bit == BIT_W'(DATA_W - 1)) begin
              tx_state <= T_STOP;
              txd_o    <= 1'b1;
            end else begin
              txd_o    <= tx_shift[0];
              tx_shift <= tx_shift >> 1;
              tx_bit   <= tx_bit + 1'b1;
            end
          end else begin
            tx_cnt <= tx_cnt - 1'b1;
          end
        end
        T_STOP: begin
          if (tx_cnt == '0) begin
            if (!tx_empty) begin
              tx_state <= T_START;
              txd_o    <= 1'b0;
              tx_shift <= tx_dout;
              tx_div   <= div_eff;
              tx_cnt   <= div_eff;
            end else if (GUARD_BITS == 0) begin
              tx_state <= T_IDLE;
              txen_o   <= 1'b0;
            end else begin
              tx_state   <= T_GUARD;
              guard_left <= G_W'(GUARD_BITS - 1);
              tx_cnt     <= tx_div;
            end
          end else begin
            tx_cnt <= tx_cnt - 1'b1;
          end
        end
        T_GUARD: begin
          if (tx_cnt == '0) begin
            if (guard_left == '0) begin
              tx_state <= T_IDLE;
              txen_o   <= 1'b0;
            end else begin
              guard_left <= guard_left - 1'b1;
              tx_cnt     <= tx_div;
            end
          end else begin
            tx_cnt <= tx_cnt - 1'b1;
          end
        end
        default: begin
          tx_state <= T_IDLE;
          txen_o   <= 1'b0;
          txd_o    <= 1'b1;
        end
      endcase
    end
  end

  always_comb begin
    stat_word              = '0;
    stat_word[S_RX_NEMPTY] = !rx_empty;
    stat_word[S_RX_FULL]   = rx_full;
    stat_word[S_TX_EMPTY]  = tx_empty;
    stat_word[S_TX_FULL]   = tx_full;
    stat_word[S_RX_OVF]    = rx_ovf;
    stat_word[S_FRM_ERR]   = frm_err;
    stat_word[S_TX_DROP]   = tx_drop;
  end

  logic w1c, tx_drop_set, rx_ovf_set, frm_err_set;
  assign w1c         = acc_wr && (addr_i == A_STAT);
  assign tx_drop_set = tx_push && tx_full && !tx_pop;
  assign rx_ovf_set  = rx_push && rx_full && !rx_pop;
  assign frm_err_set = rx_stop_tick && !rxd_s;

  // Set has priority over a same-cycle write-one-to-clear.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      div_reg <= DIV_W'(DIV_RST);
      ien     <= '0;
      tx_drop <= 1'b0;
      rx_ovf  <= 1'b0;
      frm_err <= 1'b0;
      data_o  <= '0;
      irq_o   <= 1'b0;
    end else begin
      if (acc_wr && (addr_i == A_DIV)) div_reg <= data_i[DIV_W-1:0];
      if (acc_wr && (addr_i == A_IEN)) ien     <= data_i[2:0];
      tx_drop <= (tx_drop && !(w1c && data_i[S_TX_DROP])) || tx_drop_set;
      rx_ovf  <= (rx_ovf  && !(w1c && data_i[S_RX_OVF]))  || rx_ovf_set;
      frm_err <= (frm_err && !(w1c && data_i[S_FRM_ERR])) || frm_err_set;
      if (acc_rd) begin
        case (addr_i)
          A_DATA:  data_o <= rx_empty ? '0 : 16'(rx_dout);
          A_STAT:  data_o <= stat_word;
          A_DIV:   data_o <= 16'(div_reg);
          default: data_o <= {13'b0, ien};
        endcase
      end
      irq_o <= |(ien & {tx_drop || rx_ovf || frm_err, tx_empty, !rx_empty});
    end
  end

endmodule

// File: tb/tb_uart_hdx_ctrl.sv
// tb/tb_uart_hdx_ctrl.sv - scoreboard bench: register reads and serial TX frames checked against queued expectations
module tb_uart_hdx_ctrl;

  logic        clk_i = 1'b0;
  logic        reset_i = 1'b1;
  logic        ce_i = 1'b0, wr_i = 1'b0, rd_i = 1'b0;
  logic [1:0]  addr_i = 2'd0;
  logic [15:0] data_i = 16'd0;
  logic [15:0] data_o;
  logic        irq_o, rxd_i, txd_o, txen_o;
  logic        rxd_drv = 1'b1;
  logic        loopback = 1'b0;
  logic        rd_d = 1'b0;

  int          n_cmp = 0;
  int          n_fail = 0;
  int          cur_period = 435;

  logic [15:0] exp_rd[$];
  string       exp_nm[$];
  logic [7:0]  exp_tx[$];
  int          exp_burst[$];
  logic [7:0]  rx_model[$];

  assign rxd_i = loopback ? txd_o : rxd_drv;

  uart_hdx_ctrl dut (
    .clk_i(clk_i), .reset_i(reset_i), .ce_i(ce_i), .wr_i(wr_i), .rd_i(rd_i),
    .addr_i(addr_i), .data_i(data_i), .data_o(data_o), .irq_o(irq_o),
    .rxd_i(rxd_i), .txd_o(txd_o), .txen_o(txen_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic check(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic missing(input string name);
    n_cmp++;
    n_fail++;
    $display("FAIL %s: DUT output with no expectation queued", name);
  endtask

  // Read-data monitor: data_o is due one cycle after each read access.
  always @(posedge clk_i) rd_d <= ce_i && rd_i && !wr_i;

  always @(negedge clk_i) begin
    if (rd_d) begin
      if (exp_rd.size() == 0) missing("rd_data");
      else check(exp_nm.pop_front(), int'(data_o), int'(exp_rd.pop_front()));
    end
  end

  // Serial TX monitor: decodes each burst, checks lead, frame spacing, bytes and total length.
  initial begin : tx_mon
    int t, k, ts, tprev, n, nexp;
    logic [7:0] b;
    forever begin
      do @(negedge clk_i); while (!txen_o);
      t = 0; n = 0; tprev = 0;
      forever begin
        k = 0;
        while (txd_o && txen_o && k < 20 * cur_period) begin
          @(negedge clk_i); t++; k++;
        end
        if (!txen_o) break;
        if (k >= 20 * cur_period) begin
          n_cmp++; n_fail++;
          $display("FAIL tx_timeout: line idle for %0d cycles with txen high", k);
          break;
        end
        ts = t;
        if (n == 0) check("tx_lead", ts, cur_period);
        else        check("tx_gap", ts - tprev, 10 * cur_period);
        tprev = ts;
        repeat (cur_period / 2) @(negedge clk_i);
        for (int i = 0; i < 8; i++) begin
          repeat (cur_period) @(negedge clk_i);
          b[i] = txd_o;
        end
        repeat (cur_period) @(negedge clk_i);
        check("tx_stop", int'(txd_o), 1);
        t = ts + cur_period / 2 + 9 * cur_period;
        n++;
        if (exp_tx.size() == 0) missing("tx_byte");
        else check("tx_byte", int'(b), int'(exp_tx.pop_front()));
      end
      if (exp_burst.size() == 0) begin
        missing("tx_burst");
      end else begin
        nexp = exp_burst.pop_front();
        check("tx_frames", n, nexp);
        check("tx_len", t, cur_period * (2 + 10 * nexp));
      end
    end
  end

  task automatic reg_write(input logic [1:0] a, input logic [15:0] d);
    @(negedge clk_i);
    ce_i = 1'b1; wr_i = 1'b1; addr_i = a; data_i = d;
    @(negedge clk_i);
    ce_i = 1'b0; wr_i = 1'b0;
  endtask

  task automatic reg_read(input logic [1:0] a, input logic [15:0] e, input string nm);
    @(negedge clk_i);
    ce_i = 1'b1; rd_i = 1'b1; addr_i = a;
    exp_rd.push_back(e);
    exp_nm.push_back(nm);
    @(negedge clk_i);
    ce_i = 1'b0; rd_i = 1'b0;
  endtask

  task automatic tx_write(input logic [7:0] b);
    exp_tx.push_back(b);
    reg_write(2'd0, {8'h00, b});
  endtask

  task automatic send_frame(input logic [7:0] b, input logic stop_ok);
    rxd_drv = 1'b0;
    repeat (cur_period) @(negedge clk_i);
    for (int i = 0; i < 8; i++) begin
      rxd_drv = b[i];
      repeat (cur_period) @(negedge clk_i);
    end
    rxd_drv = stop_ok;
    repeat (cur_period) @(negedge clk_i);
    rxd_drv = 1'b1;
    repeat (2 * cur_period) @(negedge clk_i);
  endtask

  task automatic wait_tx_done();
    int k = 0;
    while (exp_burst.size() != 0 && k < 5000) begin
      @(negedge clk_i); k++;
    end
    check("tx_done", exp_burst.size(), 0);
  endtask

  initial begin : stim
    logic [7:0] b, rb;
    repeat (3) @(negedge clk_i);
    check("rst_txd", int'(txd_o), 1);
    check("rst_txen", int'(txen_o), 0);
    check("rst_data_o", int'(data_o), 0);
    check("rst_irq", int'(irq_o), 0);
    reset_i = 1'b0;
    reg_read(2'd1, 16'h0004, "rst_stat");
    reg_read(2'd2, 16'd434, "rst_div");
    reg_read(2'd3, 16'h0000, "rst_ien");

    reg_write(2'd2, 16'd9);
    cur_period = 10;
    reg_read(2'd2, 16'd9, "div_rb");

    exp_burst.push_back(1);
    tx_write(8'h55);
    wait_tx_done();

    loopback = 1'b1;
    exp_burst.push_back(1);
    tx_write(8'hA3);
    wait_tx_done();
    repeat (20) @(negedge clk_i);
    loopback = 1'b0;
    reg_read(2'd1, 16'h0004, "echo_stat");

    send_frame(8'h3C, 1'b1);
    reg_read(2'd1, 16'h0005, "rx_stat");
    reg_write(2'd3, 16'h0001);
    repeat (2) @(negedge clk_i);
    check("irq_rx", int'(irq_o), 1);
    reg_read(2'd0, 16'h003C, "rx_data");
    repeat (2) @(negedge clk_i);
    check("irq_rx_clr", int'(irq_o), 0);
    reg_read(2'd0, 16'h0000, "rx_empty_rd");
    reg_write(2'd3, 16'h0000);

    for (int i = 0; i < 17; i++) begin
      b = 8'($urandom);
      if (i < 16) rx_model.push_back(b);
      send_frame(b, 1'b1);
    end
    reg_read(2'd1, 16'h0017, "ovf_stat");
    reg_write(2'd1, 16'h0010);
    reg_read(2'd1, 16'h0007, "ovf_clr_stat");
    while (rx_model.size() != 0) reg_read(2'd0, {8'h00, rx_model.pop_front()}, "ovf_data");
    reg_read(2'd1, 16'h0004, "drain_stat");

    reg_write(2'd3, 16'h0004);
    repeat (2) @(negedge clk_i);
    check("irq_idle", int'(irq_o), 0);
    send_frame(8'($urandom), 1'b0);
    check("irq_frm", int'(irq_o), 1);
    reg_read(2'd1, 16'h0024, "frm_stat");
    reg_write(2'd1, 16'h0020);
    repeat (2) @(negedge clk_i);
    check("irq_frm_clr", int'(irq_o), 0);
    reg_read(2'd1, 16'h0004, "frm_clr_stat");
    reg_write(2'd3, 16'h0000);

    exp_burst.push_back(3);
    for (int i = 0; i < 3; i++) tx_write(8'($urandom));
    wait_tx_done();

    b  = 8'($urandom);
    rb = 8'($urandom);
    exp_burst.push_back(1);
    fork
      send_frame(rb, 1'b1);
      begin
        repeat (5) @(negedge clk_i);
        tx_write(b);
        repeat (70) @(negedge clk_i);
        check("arb_hold", int'(txen_o), 0);
      end
    join
    wait_tx_done();
    reg_read(2'd0, {8'h00, rb}, "arb_rx");

    reg_write(2'd2, 16'd1);
    cur_period = 4;
    reg_read(2'd2, 16'd1, "div_min_rb");
    exp_burst.push_back(1);
    tx_write(8'($urandom));
    wait_tx_done();
    rb = 8'($urandom);
    send_frame(rb, 1'b1);
    reg_read(2'd0, {8'h00, rb}, "div_min_rx");

    repeat (5) @(negedge clk_i);
    check("rd_queue_left", exp_rd.size(), 0);
    check("tx_queue_left", exp_tx.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
